message_stream_arbiter: RTL and testbench
=========================================

MESSAGE_STREAM_ARBITER -- requirements
Module: message_stream_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- N_STREAMS, 4, input stream count
- LOG_N_STREAMS, 2, clog2(N_STREAMS)
- WIDTH, 32, word width
- BUFFER_DEPTH, 16, per-stream FIFO depth in words (power of 2)
- LOG_BUFFER_DEPTH, 4, log2(BUFFER_DEPTH)
- LOG_MAX_PACKET_LENGTH, 10, header length-field width (must be ≤ WIDTH-1)
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock
- rst_n, in, 1, reset: asynchronous, active-low
- in_data, in, WIDTH*N_STREAMS, stream j at bits [WIDTH*(j+1)-1 -: WIDTH]
- in_nd, in, N_STREAMS, per-stream word valid
- in_ready, out, N_STREAMS, per-stream FIFO not full
- out_data, out, WIDTH, output word
- out_nd, out, 1, output word valid
- out_ready, in, 1, downstream accepts out_data
- overflow, out, N_STREAMS, sticky per-stream dropped-word flags
- error, out, 1, sticky: any overflow or framing error

Function
REQ-003 Word format SHALL be: bit WIDTH-1 = 1 marks header; header bits [WIDTH-2 -: LOG_MAX_PACKET_LENGTH] = L, the number of data words following the header.
REQ-004 Each stream SHALL own a BUFFER_DEPTH-word FIFO; in_ready[j] SHALL equal "FIFO j not full", from registered occupancy.
REQ-005 in_nd[j]=1 with in_ready[j]=1 SHALL write in_data word j at the clk edge; in_nd[j]=1 with in_ready[j]=0 SHALL drop the word and set overflow[j] and error.
REQ-006 Pop and push on the same FIFO in one cycle SHALL both succeed (occupancy unchanged); a full FIFO SHALL NOT accept a push even if popped that cycle.
REQ-007 Output register SHALL be free when out_nd=0 or out_ready=1; out_data/out_nd SHALL hold unchanged while out_nd=1 and out_ready=0.
REQ-008 FSM states SHALL be IDLE and PACKET.
REQ-009 IDLE: when output free and any FIFO non-empty, grant SHALL go to first non-empty stream searching from (last_grant+1) mod N_STREAMS; last_grant SHALL update to it.
REQ-010 IDLE, granted head is header with L>0: pop, output it, lock stream, remaining<=L, go PACKET.
REQ-011 IDLE, granted head is header with L=0: pop, output it, stay IDLE.
REQ-012 IDLE, granted head not a header: pop and discard (no out_nd), set error, stay IDLE.
REQ-013 PACKET: when output free and locked FIFO non-empty, pop, output, decrement remaining; on reaching 0 go IDLE; all other streams SHALL stall until then (packets never interleave).
REQ-014 Latency: word written at edge k into an empty FIFO with FSM IDLE and output free SHALL appear with out_nd=1 after edge k+1.
REQ-015 Throughput SHALL be one word per cycle sustained while out_ready=1 and source non-empty.

Reset
REQ-016 rst_n=0 SHALL asynchronously: empty all FIFOs, FSM=IDLE, last_grant=N_STREAMS-1, out_data=0, out_nd=0, overflow=0, error=0; in_ready SHALL read all ones.
REQ-017 Reset mid-packet SHALL discard the partial packet; no further words of it SHALL be output.

Configuration
REQ-018 With macro MSG_STREAM_ARBITER_STREAM_ID_EN defined, output port out_stream (LOG_N_STREAMS bits, reset 0) SHALL carry the source stream of out_data, valid with out_nd; without it the port and its logic SHALL be absent, all other behaviour identical.

Verification
REQ-019 Stream 0 sends header L=2 + 2 words, out_ready=1 -> three words out, consecutive cycles, first after edge k+1.
REQ-020 Streams 0..3 each queue one L=1 packet simultaneously -> output order streams 0,1,2,3, no interleave, 8 words.
REQ-021 Stream 1 mid-packet (L=3) with stream 2 data pending -> all stream 1 words precede any stream 2 word.
REQ-022 out_ready=0 with BUFFER_DEPTH+1 writes to stream 3 -> in_ready[3]=0 after 16 words, 17th dropped, overflow=4'b1000, error=1, out_data held.
REQ-023 Non-header word 0x0000_0005 at stream 0 head -> discarded, error=1, no out_nd; following header L=0 output normally.
REQ-024 rst_n low for one cycle mid-packet -> all outputs zero immediately, in_ready=4'b1111, next packet arbitrated from stream 0.

Source files
------------

// File: rtl/message_stream_arbiter.sv
// Packet-aware round-robin arbiter merging N_STREAMS word streams through per-stream FIFOs.
// Define MSG_STREAM_ARBITER_STREAM_ID_EN to add the out_stream source-id output.

module message_stream_fifo #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int LOG_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr, rd_ptr;
  logic [LOG_DEPTH:0]   count;
  logic               do_push, do_pop;

  assign full    = (count == (LOG_DEPTH+1)'(DEPTH));
  assign empty   = (count == '0);
  // A full FIFO refuses a push even when it is popped in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{LOG_DEPTH{1'b0}}, do_push} - {{LOG_DEPTH{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end
endmodule

module message_stream_arbiter #(
  parameter int N_STREAMS             = 4,
  parameter int LOG_N_STREAMS         = 2,
  parameter int WIDTH                 = 32,
  parameter int BUFFER_DEPTH          = 16,
  parameter int LOG_BUFFER_DEPTH      = 4,
  parameter int LOG_MAX_PACKET_LENGTH = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH*N_STREAMS-1:0] in_data,
  input  logic [N_STREAMS-1:0]       in_nd,
  output logic [N_STREAMS-1:0]       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_nd,
  input  logic                       out_ready,
  output logic [N_STREAMS-1:0]       overflow,
  output logic                       error
`ifdef MSG_STREAM_ARBITER_STREAM_ID_EN
  ,output logic [LOG_N_STREAMS-1:0]  out_stream
`endif
);
  typedef enum logic {IDLE, PACKET} state_t;

  state_t                           state;
  logic [LOG_N_STREAMS-1:0]         last_grant, lock, grant, src, idx;
  logic [LOG_MAX_PACKET_LENGTH-1:0] remaining, hdr_len;
  logic [N_STREAMS-1:0]             fifo_full, fifo_empty, pop, drop;
  logic [N_STREAMS-1:0][WIDTH-1:0]  head;
  logic [WIDTH-1:0]                 src_head;
  logic                             grant_vld, src_avail, out_free, take, is_hdr, discard;

  genvar j;
  generate
    for (j = 0; j < N_STREAMS; j++) begin : g_lane
      message_stream_fifo #(
        .WIDTH(WIDTH), .DEPTH(BUFFER_DEPTH), .LOG_DEPTH(LOG_BUFFER_DEPTH)
      ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (in_nd[j]),
        .wr_data(in_data[WIDTH*(j+1)-1 -: WIDTH]),
        .pop    (pop[j]),
        .rd_data(head[j]),
        .full   (fifo_full[j]),
        .empty  (fifo_empty[j])
      );
    end
  endgenerate

  assign in_ready = ~fifo_full;
  assign drop     = in_nd & fifo_full;
  assign out_free = ~out_nd | out_ready;

  // Round-robin search starting one past the last granted stream.
  always_comb begin
    grant     = last_grant;
    grant_vld = 1'b0;
    idx       = '0;
    for (int i = 1; i <= N_STREAMS; i++) begin
      if (int'(last_grant) + i >= N_STREAMS)
        idx = LOG_N_STREAMS'(int'(last_grant) + i - N_STREAMS);
      else
        idx = LOG_N_STREAMS'(int'(last_grant) + i);
      if (!grant_vld && !fifo_empty[idx]) begin
        grant     = idx;
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    src       = (state == PACKET) ? lock : grant;
    src_avail = (state == PACKET) ? ~fifo_empty[lock] : grant_vld;
    src_head  = head[src];
    is_hdr    = src_head[WIDTH-1];
    hdr_len   = src_head[WIDTH-2 -: LOG_MAX_PACKET_LENGTH];
    take      = out_free & src_avail;
    discard   = take & (state == IDLE) & ~is_hdr;
    pop       = '0;
    if (take) pop[src] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= LOG_N_STREAMS'(N_STREAMS-1);
      lock       <= '0;
      remaining  <= '0;
      out_data   <= '0;
      out_nd     <= 1'b0;
      overflow   <= '0;
      error      <= 1'b0;
`ifdef MSG_STREAM_ARBITER_STREAM_ID_EN
      out_stream <= '0;
`endif
    end else begin
      overflow <= overflow | drop;
      error    <= error | (|drop) | discard;
      if (out_free) out_nd <= 1'b0;
      if (take) begin
        if (state == IDLE) begin
          last_grant <= grant;
          if (is_hdr) begin
            out_data <= src_head;
            out_nd   <= 1'b1;
`ifdef MSG_STREAM_ARBITER_STREAM_ID_EN
            out_stream <= src;
`endif
            if (hdr_len != '0) begin
              lock      <= grant;
              remaining <= hdr_len;
              state     <= PACKET;
            end
          end
        end else begin
          out_data  <= src_head;
          out_nd    <= 1'b1;
`ifdef MSG_STREAM_ARBITER_STREAM_ID_EN
          out_stream <= src;
`endif
          remaining <= remaining - 1'b1;
          if (remaining == LOG_MAX_PACKET_LENGTH'(1)) state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_message_stream_arbiter.sv
// Bench for message_stream_arbiter: queue-based reference model checked every cycle,
// directed packet scenarios with literal expectations, then randomized traffic.

module tb_message_stream_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int D  = 16;
  localparam int LL = 10;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [W*N-1:0] in_data = '0;
  logic [N-1:0]   in_nd = '0;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic           out_nd;
  logic           out_ready = 1'b1;
  logic [N-1:0]   overflow;
  logic           error;
`ifdef MSG_STREAM_ARBITER_STREAM_ID_EN
  logic [1:0]     out_stream;
`endif

  always #5 clk = ~clk;

  message_stream_arbiter #(
    .N_STREAMS(N), .LOG_N_STREAMS(2), .WIDTH(W), .BUFFER_DEPTH(D),
    .LOG_BUFFER_DEPTH(4), .LOG_MAX_PACKET_LENGTH(LL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_nd    (in_nd),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_nd   (out_nd),
    .out_ready(out_ready),
    .overflow (overflow),
    .error    (error)
`ifdef MSG_STREAM_ARBITER_STREAM_ID_EN
    ,.out_stream(out_stream)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] hdr(input int l, input int tag);
    return {1'b1, LL'(l), 21'(tag)};
  endfunction

  // ---------------- reference model ----------------
  logic [W-1:0] q [N][$];
  int           sz [N];
  int           m_lock = -1, m_rem = 0, m_lg = N-1, m_sid = 0, m_s, m_idx;
  logic         m_out_nd = 1'b0, m_err = 1'b0, m_free;
  logic [W-1:0] m_out_data = '0, m_w;
  logic [N-1:0] m_ovf = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < N; j++) q[j].delete();
      m_lock = -1; m_rem = 0; m_lg = N-1; m_sid = 0;
      m_out_nd = 1'b0; m_out_data = '0; m_ovf = '0; m_err = 1'b0;
    end else begin
      for (int j = 0; j < N; j++) sz[j] = q[j].size();
      m_free = !m_out_nd || out_ready;
      if (m_free) begin
        m_out_nd = 1'b0;
        if (m_lock >= 0) begin
          if (sz[m_lock] > 0) begin
            m_out_data = q[m_lock].pop_front();
            m_out_nd = 1'b1;
            m_sid = m_lock;
            m_rem--;
            if (m_rem == 0) m_lock = -1;
          end
        end else begin
          m_s = -1;
          for (int i = 1; i <= N; i++) begin
            m_idx = (m_lg + i) % N;
            if (m_s < 0 && sz[m_idx] > 0) m_s = m_idx;
          end
          if (m_s >= 0) begin
            m_lg = m_s;
            m_w = q[m_s].pop_front();
            if (m_w[W-1]) begin
              m_out_data = m_w;
              m_out_nd = 1'b1;
              m_sid = m_s;
              if (int'(m_w[W-2 -: LL]) != 0) begin
                m_lock = m_s;
                m_rem = int'(m_w[W-2 -: LL]);
              end
            end else begin
              m_err = 1'b1;
            end
          end
        end
      end
      for (int j = 0; j < N; j++) begin
        if (in_nd[j]) begin
          if (sz[j] < D) q[j].push_back(in_data[W*j +: W]);
          else begin
            m_ovf[j] = 1'b1;
            m_err = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [N-1:0] exp_rdy;
  always @(negedge clk) begin
    for (int j = 0; j < N; j++) exp_rdy[j] = (q[j].size() < D);
    chk("out_nd", out_nd, m_out_nd);
    if (m_out_nd) chk("out_data", out_data, m_out_data);
`ifdef MSG_STREAM_ARBITER_STREAM_ID_EN
    if (m_out_nd) chk("out_stream", out_stream, m_sid);
`endif
    chk("in_ready", in_ready, exp_rdy);
    chk("overflow", overflow, m_ovf);
    chk("error", error, m_err);
  end

  // Words actually handed downstream, for order checks.
  logic [W-1:0] out_log[$];
  always @(posedge clk) if (rst_n && out_nd && out_ready) out_log.push_back(out_data);

  task automatic chk_log(input string name, input logic [W-1:0] exp[$]);
    chk({name, "_len"}, out_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < out_log.size(); i++) chk(name, out_log[i], exp[i]);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_word(input int j, input logic [W-1:0] w);
    in_data[W*j +: W] = w;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    in_nd = '0;
    out_log.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  int gen_rem [N];
  int waited;
  logic [W-1:0] e[$];

  initial begin
    do_reset();
    chk("rst_out_nd", out_nd, 1'b0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_in_ready", in_ready, 4'hF);
    chk("rst_overflow", overflow, 4'h0);
    chk("rst_error", error, 1'b0);

    // Single L=2 packet: header one edge after the write, then back-to-back data.
    out_ready = 1'b1;
    set_word(0, 32'h8040_0000); in_nd = 4'b0001; tick();
    set_word(0, 32'h0000_0A01); tick();
    chk("p19_hdr_nd", out_nd, 1'b1); chk("p19_hdr", out_data, 32'h8040_0000);
    set_word(0, 32'h0000_0A02); tick();
    chk("p19_d0", out_data, 32'h0000_0A01);
    in_nd = '0; tick();
    chk("p19_d1", out_data, 32'h0000_0A02); chk("p19_d1_nd", out_nd, 1'b1);
    tick();
    chk("p19_end_nd", out_nd, 1'b0);

    // Four simultaneous L=1 packets come out 0,1,2,3 without interleave.
    do_reset();
    for (int j = 0; j < N; j++) set_word(j, hdr(1, 16'h2000 + j));
    in_nd = 4'hF; tick();
    for (int j = 0; j < N; j++) set_word(j, 32'h100 + 16*j);
    tick();
    in_nd = '0;
    repeat (10) tick();
    e = '{32'h8020_2000, 32'h100, 32'h8020_2001, 32'h110,
          32'h8020_2002, 32'h120, 32'h8020_2003, 32'h130};
    chk_log("p20_order", e);

    // Stream 1 packet stays locked while its data trickles in; stream 2 waits.
    do_reset();
    set_word(1, hdr(3, 16'h2100)); in_nd = 4'b0010; tick();
    set_word(1, 32'h11); set_word(2, hdr(1, 16'h2200)); in_nd = 4'b0110; tick();
    set_word(2, 32'h21); in_nd = 4'b0100; tick();
    in_nd = '0; repeat (2) tick();
    set_word(1, 32'h12); in_nd = 4'b0010; tick();
    set_word(1, 32'h13); tick();
    in_nd = '0; repeat (6) tick();
    e = '{32'h8060_2100, 32'h11, 32'h12, 32'h13, 32'h8020_2200, 32'h21};
    chk_log("p21_order", e);

    // Output stalled: stream 3 fills, 17th word dropped, output held.
    do_reset();
    out_ready = 1'b0;
    set_word(0, hdr(0, 16'h0077)); in_nd = 4'b0001; tick();
    in_nd = '0;
    waited = 0;
    while (!out_nd && waited < 10) begin tick(); waited++; end
    chk("p22_hold_nd", out_nd, 1'b1);
    for (int i = 0; i <= D; i++) begin
      if (i == D) chk("p22_full", in_ready, 4'b0111);
      set_word(3, hdr(0, 16'h0300 + i)); in_nd = 4'b1000; tick();
    end
    in_nd = '0;
    chk("p22_overflow", overflow, 4'b1000);
    chk("p22_error", error, 1'b1);
    chk("p22_held", out_data, 32'h8000_0077);
    out_ready = 1'b1;
    repeat (D + 4) tick();

    // Non-header at the head is dropped; the following L=0 header passes.
    do_reset();
    set_word(0, 32'h0000_0005); in_nd = 4'b0001; tick();
    set_word(0, hdr(0, 16'h0023)); tick();
    in_nd = '0; repeat (3) tick();
    chk("p23_error", error, 1'b1);
    e = '{32'h8000_0023};
    chk_log("p23_out", e);

    // Reset mid-packet.
    do_reset();
    set_word(2, hdr(3, 16'h0024)); in_nd = 4'b0100; tick();
    set_word(2, 32'h31); tick();
    in_nd = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("p24_nd", out_nd, 1'b0); chk("p24_data", out_data, 32'h0);
    chk("p24_rdy", in_ready, 4'hF); chk("p24_ovf", overflow, 4'h0);
    chk("p24_err", error, 1'b0);
    out_log.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    set_word(0, hdr(0, 16'h0040)); set_word(1, hdr(0, 16'h0041)); set_word(2, 32'h32);
    in_nd = 4'b0111; tick();
    set_word(2, 32'h33); in_nd = 4'b0100; tick();
    in_nd = '0; repeat (6) tick();
    e = '{32'h8000_0040, 32'h8000_0041};
    chk_log("p24_after", e);

    // Randomized packet traffic.
    do_reset();
    for (int j = 0; j < N; j++) gen_rem[j] = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        do_reset();
        for (int j = 0; j < N; j++) gen_rem[j] = 0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      for (int j = 0; j < N; j++) begin
        in_nd[j] = ($urandom_range(0, 9) < 4);
        if (in_nd[j]) begin
          if ($urandom_range(0, 39) == 0) set_word(j, {1'b0, 31'($urandom)});
          else if (gen_rem[j] == 0) begin
            gen_rem[j] = $urandom_range(0, 4);
            set_word(j, hdr(gen_rem[j], $urandom));
          end else begin
            set_word(j, {1'b0, 31'($urandom)});
            gen_rem[j]--;
          end
        end
      end
      tick();
    end
    in_nd = '0; out_ready = 1'b1;
    repeat (40) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
